fifo_rr_drain: RTL and testbench
================================

# fifo_rr_drain

Round-robin read-side scheduler that shares one output stream between pN first-word-fall-through sync FIFOs (fifo_sync built with pFALLTHROUGH=1). Grants one FIFO at a time for a fixed-length burst of pBURST words, using each FIFO's empty_threshold flag to grant only FIFOs that already hold a full burst. A flush input drains partial contents at end of capture. Sits between the per-channel capture FIFOs and the single USB/readback stream.

## Interface
- pN, 4: number of requester FIFOs, 2..8.
- pDATA_WIDTH, 16: FIFO word width.
- pBURST, 8: words per full burst, 1..255; the FIFOs' empty_threshold_value is set to pBURST-1 by the integrator.

- clk  input  1  single clock, shared with all requester FIFOs.
- reset  input  1  synchronous, active-high.
- enable  input  1  allow new grants; sampled only in IDLE.
- flush  input  1  level; allow grants to any non-empty FIFO and end bursts early on empty.
- fifo_empty  input  pN  per-FIFO empty flag.
- fifo_empty_threshold  input  pN  per-FIFO "fewer than pBURST words" flag.
- fifo_rdata  input  pN*pDATA_WIDTH  FWFT head word; FIFO i at bits [i*W +: W].
- fifo_ren  output  pN  one-hot-or-zero pop strobe, combinational.
- out_data  output  pDATA_WIDTH  registered output word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts when out_valid & out_ready.
- out_source  output  clog2(pN)  index of FIFO that supplied out_data.
- out_last  output  1  qualifies the pBURST-th word of a burst.
- busy  output  1  high in BURST or while out_valid.

## Operation
- States: IDLE, BURST. Registers: state, cur (granted index), last_grant, count (clog2(pBURST+1) bits), output register.
- Eligibility of FIFO i: !fifo_empty[i] & (flush | !fifo_empty_threshold[i]).
- IDLE: if enable and any eligible, pick first eligible scanning last_grant+1, +2, ... modulo pN; cur<=pick, last_grant<=pick, count<=0, state<=BURST. Otherwise stay.
- BURST: pop_ok = !fifo_empty[cur] & (!out_valid | out_ready). fifo_ren[cur]=pop_ok; all other ren bits 0. fifo_ren is 0 in IDLE and never asserted on an empty FIFO (no underflow possible).
- On pop: out_data<=head of cur, out_source<=cur, out_valid<=1, count<=count+1, out_last<=(count==pBURST-1).
- Burst end, state<=IDLE: on the pop making count reach pBURST; or, when flush=1, any BURST cycle where fifo_empty[cur]=1 (no pop that cycle, no out_last issued for that burst).
- fifo_empty[cur] seen with flush=0: wait in BURST (defensive; cannot occur with correct threshold setting).
- Output register: out_valid clears on out_ready when no new pop that cycle; holds data/source/last stable while out_valid & !out_ready.
- enable deassert mid-burst: burst completes; no new grant. flush deassert mid-burst: burst continues to pBURST words.
- Reset: state=IDLE, last_grant=pN-1 (first search starts at 0), count=0, out_valid=0, out_last=0, out_data=0, out_source=0, busy=0, fifo_ren=0; a burst in progress is abandoned.

## Timing
- Arbitration: 1 cycle in IDLE; first pop in first BURST cycle.
- Pop to out_valid: 1 cycle. Back-to-back pops at full rate while out_ready=1.
- Burst to burst: exactly one dead cycle (IDLE) between last pop of one burst and first pop of the next.
- Full burst with out_ready held high: pBURST+1 cycles from grant decision to IDLE re-entry.
- fifo_ren depends combinationally on out_ready, fifo_empty, state, cur; no path from fifo_rdata to ren.

## Test plan
- pN=4, pBURST=8, FIFOs 0..3 each hold 16 words, out_ready=1: source order 0,1,2,3,0,1,2,3; each burst 8 words, out_last on words 8,16,...,64; one idle cycle between bursts.
- Only FIFO 2 holds 5 words, flush=0 -> no ren; raise flush -> 5 words from source 2, no out_last, return to IDLE, busy falls 1 cycle after last accept.
- out_ready toggled 1,0,0,1 pattern during burst from FIFO 1 (16 words) -> no word lost or duplicated, data order matches write order, ren never high while out_valid & !out_ready.
- Drop enable at word 3 of a burst -> burst finishes 8 words, then no further ren though FIFOs eligible; re-enable -> grant resumes at next index.
- Assert reset on word 4 of a burst -> next cycle all outputs 0, state IDLE; after release, first grant goes to FIFO 0 if eligible.
- FIFO 3 continuously eligible, FIFO 0 becomes eligible mid-burst of 3 -> next grant FIFO 0 (wrap-around), not 3.

Source files
------------

// File: rtl/fifo_rr_drain.sv
// Round-robin burst drain of pN FWFT capture FIFOs into one registered stream.
// A FIFO is granted only when it holds a full burst, or when flush allows partial drains.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no grant; choose the next eligible FIFO after last_grant
// S_BURST | popping FIFO cur until pBURST words, or until empty under flush
module fifo_rr_drain #(
  parameter int pN          = 4,
  parameter int pDATA_WIDTH = 16,
  parameter int pBURST      = 8,
  localparam int IW         = (pN > 1) ? $clog2(pN) : 1,
  localparam int CW         = $clog2(pBURST + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      flush,
  input  logic [pN-1:0]             fifo_empty,
  input  logic [pN-1:0]             fifo_empty_threshold,
  input  logic [pN*pDATA_WIDTH-1:0] fifo_rdata,
  output logic [pN-1:0]             fifo_ren,
  output logic [pDATA_WIDTH-1:0]    out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IW-1:0]             out_source,
  output logic                      out_last,
  output logic                      busy
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          cur_q, cur_d;
  logic [IW-1:0]          last_grant_q, last_grant_d;
  logic [CW-1:0]          count_q, count_d;
  logic [pDATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic [IW-1:0]          out_source_q, out_source_d;
  logic                   out_last_q, out_last_d;

  logic [pN-1:0]          elig;
  logic                   pick_valid;
  logic [IW-1:0]          pick;
  logic [IW:0]            scan_sum;
  logic [IW-1:0]          scan_idx;
  logic [pDATA_WIDTH-1:0] head;
  logic                   cur_empty;
  logic                   pop_ok;
  logic                   burst_done;

  assign elig = ~fifo_empty & ({pN{flush}} | ~fifo_empty_threshold);

  // Rotating priority: first eligible index after last_grant, modulo pN.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int k = 1; k <= pN; k++) begin
      scan_sum = {1'b0, last_grant_q} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(pN)) begin
        scan_sum = scan_sum - (IW+1)'(pN);
      end
      scan_idx = scan_sum[IW-1:0];
      if (!pick_valid && elig[scan_idx]) begin
        pick_valid = 1'b1;
        pick       = scan_idx;
      end
    end
  end

  always_comb begin
    head      = '0;
    cur_empty = 1'b1;
    for (int i = 0; i < pN; i++) begin
      if (cur_q == IW'(i)) begin
        head      = fifo_rdata[i*pDATA_WIDTH +: pDATA_WIDTH];
        cur_empty = fifo_empty[i];
      end
    end
  end

  // Reset suppresses the pop so an abandoned burst never loses an extra word.
  assign pop_ok     = (state_q == S_BURST) && !cur_empty && (!out_valid_q || out_ready) && !reset;
  assign burst_done = (count_q == CW'(pBURST - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      last_grant_q <= IW'(pN - 1);
      count_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_source_q <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_source_q <= out_source_d;
      out_last_q   <= out_last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_source_d = out_source_q;
    out_last_d   = out_last_q;

    case (state_q)
      S_IDLE: begin
        if (enable && pick_valid) begin
          state_d      = S_BURST;
          cur_d        = pick;
          last_grant_d = pick;
          count_d      = '0;
        end
      end
      S_BURST: begin
        if (pop_ok) begin
          count_d = count_q + CW'(1);
          if (burst_done) begin
            state_d = S_IDLE;
          end
        end else if (cur_empty && flush) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop_ok) begin
      out_data_d   = head;
      out_source_d = cur_q;
      out_valid_d  = 1'b1;
      out_last_d   = burst_done;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_comb begin
    fifo_ren = '0;
    if (pop_ok) begin
      fifo_ren[cur_q] = 1'b1;
    end
    busy = (state_q == S_BURST) || out_valid_q;
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_source = out_source_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Directed bench for fifo_rr_drain: behavioural FWFT FIFOs feed the DUT and a
// scoreboard of predicted words is checked at every accepted output beat.
module tb_fifo_rr_drain;
  localparam int N = 4;
  localparam int W = 16;
  localparam int B = 8;
  localparam int D = 64;

  logic           clk = 1'b0;
  logic           reset, enable, flush, out_ready;
  logic [N-1:0]   fifo_empty, fifo_empty_threshold, fifo_ren;
  logic [N*W-1:0] fifo_rdata;
  logic [W-1:0]   out_data;
  logic           out_valid, out_last, busy;
  logic [1:0]     out_source;

  fifo_rr_drain #(.pN(N), .pDATA_WIDTH(W), .pBURST(B)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_empty_threshold(fifo_empty_threshold),
    .fifo_rdata(fifo_rdata), .fifo_ren(fifo_ren),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_source(out_source), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO models: pushes from the stimulus, pops from ren sampled mid-cycle.
  logic [W-1:0] mem [N][D];
  int           wptr [N];
  int           rptr [N];
  logic [N-1:0] ren_s;
  int           cyc;

  always_comb begin
    fifo_empty           = '0;
    fifo_empty_threshold = '0;
    fifo_rdata           = '0;
    for (int i = 0; i < N; i++) begin
      fifo_empty[i]           = (wptr[i] - rptr[i]) == 0;
      fifo_empty_threshold[i] = (wptr[i] - rptr[i]) < B;
      fifo_rdata[i*W +: W]    = mem[i][rptr[i] % D];
    end
  end

  always @(negedge clk) ren_s <= fifo_ren;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (ren_s[i] === 1'b1) rptr[i] <= rptr[i] + 1;
    end
  end

  typedef struct packed {
    logic [W-1:0] d;
    logic [1:0]   s;
    logic         l;
  } exp_t;

  exp_t sb[$];
  int   exp_rd [N];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   gap_en = 1'b0;
  int   last_acc = -1;
  bit   prev_last = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] word_of(int ch, int k);
    return W'(ch * 4096 + (k % 4096));
  endfunction

  task automatic push_words(int ch, int n);
    for (int j = 0; j < n; j++) begin
      mem[ch][wptr[ch] % D] = word_of(ch, wptr[ch]);
      wptr[ch]++;
    end
  endtask

  task automatic expect_burst(int ch, int n, bit with_last);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e.d = word_of(ch, exp_rd[ch]);
      e.s = 2'(ch);
      e.l = with_last && (j == n - 1);
      sb.push_back(e);
      exp_rd[ch]++;
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(string tag, int maxc);
    int k = 0;
    while ((sb.size() != 0 || busy) && k < maxc) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({tag, "_sb_left"}, sb.size(), 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("ren_onehot", $onehot0(fifo_ren), 1);
      chk("ren_on_empty", fifo_ren & fifo_empty, 0);
      chk("ren_while_stalled", (|fifo_ren) && out_valid && !out_ready, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("extra_word_valid", out_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("data", out_data, e.d);
          chk("source", out_source, e.s);
          chk("last", out_last, e.l);
          if (gap_en && last_acc >= 0) chk("accept_gap", cyc - last_acc, prev_last ? 2 : 1);
          last_acc  = cyc;
          prev_last = out_last;
        end
      end
    end
  end

  initial begin
    int k, b0, b1, b2, b3;
    int pat [4] = '{1, 0, 0, 1};
    reset = 1'b1; enable = 1'b0; flush = 1'b0; out_ready = 1'b1;
    step(3);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_source", out_source, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ren", fifo_ren, 0);
    reset = 1'b0;
    step(1);

    // Full round robin, two passes, full rate.
    for (int ch = 0; ch < N; ch++) push_words(ch, 16);
    for (int r = 0; r < 2; r++)
      for (int ch = 0; ch < N; ch++) expect_burst(ch, B, 1'b1);
    gap_en = 1'b1;
    enable = 1'b1;
    wait_drain("t1", 300);
    gap_en = 1'b0;
    step(1);

    // Partial FIFO waits for flush.
    push_words(2, 5);
    b2 = rptr[2];
    step(20);
    chk("t2_no_pop", rptr[2] - b2, 0);
    chk("t2_idle", busy, 0);
    expect_burst(2, 5, 1'b0);
    flush = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("t2_drained", sb.size(), 0);
    @(negedge clk);
    chk("t2_busy_fall", busy, 0);
    chk("t2_valid_fall", out_valid, 0);
    step(1);
    flush = 1'b0;

    // Backpressure pattern on two bursts from FIFO 1.
    push_words(1, 16);
    expect_burst(1, B, 1'b1);
    expect_burst(1, B, 1'b1);
    k = 0;
    while ((sb.size() != 0 || busy) && k < 300) begin
      out_ready = pat[k % 4][0];
      step(1);
      k++;
    end
    out_ready = 1'b1;
    chk("t3_sb_left", sb.size(), 0);
    chk("t3_busy", busy, 0);

    // Enable dropped on word 3 lets the burst finish, then holds off.
    enable = 1'b0;
    step(1);
    push_words(0, 8); push_words(2, 8); push_words(3, 8);
    expect_burst(2, B, 1'b1);
    b0 = rptr[0]; b2 = rptr[2]; b3 = rptr[3];
    enable = 1'b1;
    k = 0;
    while (rptr[2] - b2 < 3 && k < 50) begin
      step(1);
      k++;
    end
    enable = 1'b0;
    chk("t4_word3", rptr[2] - b2, 3);
    wait_drain("t4a", 100);
    step(20);
    chk("t4_no_regrant", (rptr[0] - b0) + (rptr[3] - b3), 0);
    chk("t4_idle", busy, 0);
    expect_burst(3, B, 1'b1);
    expect_burst(0, B, 1'b1);
    enable = 1'b1;
    wait_drain("t4b", 100);

    // Reset on word 4 abandons the burst; the popped fourth word is lost.
    enable = 1'b0;
    step(1);
    push_words(1, 8); push_words(0, 8);
    expect_burst(1, 3, 1'b0);
    exp_rd[1]++;
    b1 = rptr[1];
    enable = 1'b1;
    k = 0;
    while (rptr[1] - b1 < 4 && k < 50) begin
      step(1);
      k++;
    end
    reset = 1'b1;
    chk("t5_pops_before_reset", rptr[1] - b1, 4);
    step(1);
    chk("t5_valid", out_valid, 0);
    chk("t5_last", out_last, 0);
    chk("t5_data", out_data, 0);
    chk("t5_source", out_source, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ren", fifo_ren, 0);
    chk("t5_sb_consumed", sb.size(), 0);
    reset = 1'b0;
    expect_burst(0, B, 1'b1);
    wait_drain("t5", 100);
    chk("t5_no_pop_during_reset", rptr[1] - b1, 4);
    expect_burst(1, 4, 1'b0);
    flush = 1'b1;
    wait_drain("t5f", 100);
    flush = 1'b0;
    step(1);

    // FIFO 0 becoming eligible mid-burst of 3 wins the next grant.
    b3 = rptr[3];
    push_words(3, 16);
    expect_burst(3, B, 1'b1);
    expect_burst(0, B, 1'b1);
    expect_burst(3, B, 1'b1);
    k = 0;
    while (rptr[3] - b3 < 3 && k < 50) begin
      step(1);
      k++;
    end
    push_words(0, 8);
    wait_drain("t6", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
